// File: rtl/barrier_handshake_ctrl.sv
// ---------------------------------------------------------------------------
// barrier_handshake_ctrl
//
// Participant-facing control for a single barrier, wrapped around an external
// presence detector. Each participant's sync request (valid/ready) is turned
// into a one-cycle present pulse for the detector. When the detector reports
// that everyone is present, every participant gets a wake handshake. After the
// last wake is consumed, the detector is cleared for one cycle and the
// barrier re-opens. The block also keeps an epoch counter of completed
// barriers, flags duplicate requests and, optionally, flags a slow arrival
// phase.
//
// Ports
//   clk_i          clock
//   rstn_i         asynchronous active-low reset (shared with the detector)
//   req_valid_i    [P]  participant i requests barrier entry
//   req_ready_o    [P]  request accepted when valid & ready (same for all i)
//   present_o      [P]  to detector present_i, one pulse per new arrival
//   all_present_i       from detector all_present_o
//   clear_o             to detector clear_i, one-cycle pulse
//   wake_valid_o   [P]  wake pending for participant i
//   wake_ready_i   [P]  participant i consumes its wake
//   epoch_o        [CNT_W] completed barriers, modulo 2^CNT_W
//   dup_err_o           one-cycle pulse after a request from an arrived participant
//   timeout_o           one-cycle pulse after TIMEOUT cycles in COLLECT
// ---------------------------------------------------------------------------
module barrier_handshake_ctrl #(
    parameter int PARTICIPANTS = 4,
    parameter int CNT_W        = 8,
    parameter int TIMEOUT      = 0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [PARTICIPANTS-1:0] req_valid_i,
    output logic [PARTICIPANTS-1:0] req_ready_o,
    output logic [PARTICIPANTS-1:0] present_o,
    input  logic                    all_present_i,
    output logic                    clear_o,
    output logic [PARTICIPANTS-1:0] wake_valid_o,
    input  logic [PARTICIPANTS-1:0] wake_ready_i,
    output logic [CNT_W-1:0]        epoch_o,
    output logic                    dup_err_o,
    output logic                    timeout_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WAKE    = 2'd2;
    localparam logic [1:0] ST_CLEAR   = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [PARTICIPANTS-1:0] arrived_q, arrived_d;
    logic [PARTICIPANTS-1:0] wake_pend_q, wake_pend_d;
    logic [CNT_W-1:0]        epoch_q, epoch_d;
    logic                    dup_err_q, dup_err_d;
    logic                    accepting;
    logic [PARTICIPANTS-1:0] accept;

    // Ready is gated by rstn_i so every output reads 0 while reset is held,
    // even though the FSM already sits in IDLE.
    assign accepting    = rstn_i & ((state_q == ST_IDLE) | (state_q == ST_COLLECT));
    assign req_ready_o  = {PARTICIPANTS{accepting}};
    assign accept       = req_valid_i & req_ready_o;
    // Duplicates are accepted (so the requester is not stalled) but never
    // forwarded to the detector.
    assign present_o    = accept & ~arrived_q;
    assign wake_valid_o = wake_pend_q;
    assign clear_o      = (state_q == ST_CLEAR);
    assign epoch_o      = epoch_q;
    assign dup_err_o    = dup_err_q;

    always_comb begin
        state_d     = state_q;
        arrived_d   = arrived_q;
        wake_pend_d = wake_pend_q;
        epoch_d     = epoch_q;
        dup_err_d   = |(accept & arrived_q);
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                arrived_d = arrived_q | accept;
                // all_present_i may rise in the same cycle as the final
                // accept when the detector is combinational.
                if (all_present_i) begin
                    state_d     = ST_WAKE;
                    wake_pend_d = '1;
                end else if ((state_q == ST_IDLE) && (|accept)) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WAKE: begin
                // all_present_i is ignored here; a registered detector keeps
                // it high until the clear.
                wake_pend_d = wake_pend_q & ~wake_ready_i;
                if (wake_pend_d == '0) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                arrived_d = '0;
                epoch_d   = epoch_q + CNT_W'(1);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            arrived_q   <= '0;
            wake_pend_q <= '0;
            epoch_q     <= '0;
            dup_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            arrived_q   <= arrived_d;
            wake_pend_q <= wake_pend_d;
            epoch_q     <= epoch_d;
            dup_err_q   <= dup_err_d;
        end
    end

    if (TIMEOUT > 0) begin : g_tmo
        localparam int              TW      = $clog2(TIMEOUT + 1);
        localparam logic [TW-1:0]   TMO_MAX = TW'(TIMEOUT);

        logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
        logic          tmo_fired_q, tmo_fired_d;
        logic          tmo_hit;

        // Fires once per barrier; the counter saturates so it cannot wrap
        // back into another hit.
        assign tmo_hit   = (state_q == ST_COLLECT) && (tmo_cnt_q == TMO_MAX) && !tmo_fired_q;
        assign timeout_o = tmo_hit;

        always_comb begin
            tmo_cnt_d   = tmo_cnt_q;
            tmo_fired_d = tmo_fired_q;
            if (state_q == ST_CLEAR) begin
                tmo_cnt_d   = '0;
                tmo_fired_d = 1'b0;
            end else if (state_q == ST_COLLECT) begin
                if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
                if (tmo_hit) begin
                    tmo_fired_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                tmo_cnt_q   <= '0;
                tmo_fired_q <= 1'b0;
            end else begin
                tmo_cnt_q   <= tmo_cnt_d;
                tmo_fired_q <= tmo_fired_d;
            end
        end
    end else begin : g_no_tmo
        assign timeout_o = 1'b0;
    end

endmodule

// File: tb/tb_barrier_handshake_ctrl.sv
// ---------------------------------------------------------------------------
// tb_barrier_handshake_ctrl
//
// Directed bench for barrier_handshake_ctrl. u0 is a 4-participant instance
// (CNT_W=2, TIMEOUT=10); u1 is a single-participant instance without timeout.
// A small behavioural presence detector sits next to each instance; u0's can
// be switched between registered (comb_mode=0) and combinational output.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_barrier_handshake_ctrl;

    logic       clk;
    logic       rstn;
    logic [3:0] req_valid, req_ready, present, wake_valid, wake_ready;
    logic       all_present, clear, dup_err, timeout;
    logic [1:0] epoch;
    logic [3:0] seen;
    logic       comb_mode;

    logic       rv1, rr1, pr1, ap1, cl1, wv1, wr1, de1, to1, seen1;
    logic [7:0] ep1;

    int total;
    int bad;

    barrier_handshake_ctrl #(.PARTICIPANTS(4), .CNT_W(2), .TIMEOUT(10)) u0 (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .present_o(present), .all_present_i(all_present), .clear_o(clear),
        .wake_valid_o(wake_valid), .wake_ready_i(wake_ready), .epoch_o(epoch),
        .dup_err_o(dup_err), .timeout_o(timeout)
    );

    barrier_handshake_ctrl #(.PARTICIPANTS(1), .CNT_W(8), .TIMEOUT(0)) u1 (
        .clk_i(clk), .rstn_i(rstn), .req_valid_i(rv1), .req_ready_o(rr1),
        .present_o(pr1), .all_present_i(ap1), .clear_o(cl1),
        .wake_valid_o(wv1), .wake_ready_i(wr1), .epoch_o(ep1),
        .dup_err_o(de1), .timeout_o(to1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural presence detectors
    always @(posedge clk or negedge rstn) begin
        if (!rstn)      seen <= '0;
        else if (clear) seen <= '0;
        else            seen <= seen | present;
    end
    assign all_present = comb_mode ? &(seen | present) : &seen;

    always @(posedge clk or negedge rstn) begin
        if (!rstn)    seen1 <= 1'b0;
        else if (cl1) seen1 <= 1'b0;
        else          seen1 <= seen1 | pr1;
    end
    assign ap1 = seen1 | pr1;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        req_valid = '0; wake_ready = '0; rv1 = 1'b0; wr1 = 1'b0;
        cyc();
        cyc();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        req_valid = 4'b1111; wake_ready = '0; rv1 = 1'b1; wr1 = 1'b0;
        #1;
        total++;
        if ({req_ready, present, clear, wake_valid, epoch, dup_err, timeout} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {req_ready, present, clear, wake_valid, epoch, dup_err, timeout});
        end
        total++;
        if ({rr1, pr1, cl1, wv1, ep1, de1, to1} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs_p1 got=%b exp=0", {rr1, pr1, cl1, wv1, ep1, de1, to1});
        end
        cyc();
        req_valid = '0; rv1 = 1'b0;
        rstn = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b1111) begin
            bad++; $display("FAIL reset_ready got=%b exp=1111", req_ready);
        end
        total++;
        if (rr1 !== 1'b1) begin
            bad++; $display("FAIL reset_ready_p1 got=%b exp=1", rr1);
        end
    endtask

    // One participant per cycle, registered detector
    task automatic test_sequential();
        logic [3:0] onehot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        comb_mode = 1'b0;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            cyc();
            req_valid = onehot[c-1];
            #1;
            total++;
            if (present !== onehot[c-1]) begin
                bad++; $display("FAIL t1_present c%0d got=%b exp=%b", c, present, onehot[c-1]);
            end
        end
        cyc(); req_valid = '0; wake_ready = 4'b1111; #1;
        total++;
        if ({wake_valid, req_ready} !== 8'b0000_1111) begin
            bad++; $display("FAIL t1_c5 got=%b exp=00001111", {wake_valid, req_ready});
        end
        cyc(); #1;
        total++;
        if ({wake_valid, req_ready} !== 8'b1111_0000) begin
            bad++; $display("FAIL t1_wake got=%b exp=11110000", {wake_valid, req_ready});
        end
        cyc(); #1;
        total++;
        if ({clear, epoch, wake_valid} !== 7'b1_00_0000) begin
            bad++; $display("FAIL t1_clear got=%b exp=1000000", {clear, epoch, wake_valid});
        end
        cyc(); wake_ready = '0; #1;
        total++;
        if ({clear, epoch, req_ready} !== 7'b0_01_1111) begin
            bad++; $display("FAIL t1_done got=%b exp=0011111", {clear, epoch, req_ready});
        end
    endtask

    // All four in one cycle, combinational detector
    task automatic test_all_at_once();
        comb_mode = 1'b1;
        do_reset();
        cyc(); req_valid = 4'b1111; #1;
        total++;
        if ({present, wake_valid} !== 8'b1111_0000) begin
            bad++; $display("FAIL t2_present got=%b exp=11110000", {present, wake_valid});
        end
        cyc(); req_valid = '0; wake_ready = 4'b1111; #1;
        total++;
        if ({present, wake_valid} !== 8'b0000_1111) begin
            bad++; $display("FAIL t2_wake got=%b exp=00001111", {present, wake_valid});
        end
        cyc(); #1;
        total++;
        if (clear !== 1'b1) begin
            bad++; $display("FAIL t2_clear got=%b exp=1", clear);
        end
        cyc(); wake_ready = '0; #1;
        total++;
        if ({clear, epoch, req_ready} !== 7'b0_01_1111) begin
            bad++; $display("FAIL t2_done got=%b exp=0011111", {clear, epoch, req_ready});
        end
    endtask

    // Wakes consumed one by one, participant 2 last after a long stall
    task automatic test_staggered_wake();
        comb_mode = 1'b1;
        do_reset();
        cyc(); req_valid = 4'b1111; #1;
        cyc(); req_valid = '0; wake_ready = 4'b0001; #1;
        total++;
        if (wake_valid !== 4'b1111) begin
            bad++; $display("FAIL t3_wv0 got=%b exp=1111", wake_valid);
        end
        cyc(); wake_ready = 4'b0010; #1;
        total++;
        if (wake_valid !== 4'b1110) begin
            bad++; $display("FAIL t3_wv1 got=%b exp=1110", wake_valid);
        end
        cyc(); wake_ready = 4'b1000; #1;
        total++;
        if (wake_valid !== 4'b1100) begin
            bad++; $display("FAIL t3_wv2 got=%b exp=1100", wake_valid);
        end
        // Ready on already-consumed bits must not affect bit 2
        for (int c = 0; c < 5; c++) begin
            cyc(); wake_ready = 4'b1011; #1;
            total++;
            if ({wake_valid, clear} !== 5'b0100_0) begin
                bad++; $display("FAIL t3_hold c%0d got=%b exp=01000", c, {wake_valid, clear});
            end
        end
        cyc(); wake_ready = 4'b0100; #1;
        cyc(); wake_ready = '0; #1;
        total++;
        if ({clear, wake_valid} !== 5'b1_0000) begin
            bad++; $display("FAIL t3_clear got=%b exp=10000", {clear, wake_valid});
        end
        cyc(); #1;
        total++;
        if ({clear, epoch} !== 3'b0_01) begin
            bad++; $display("FAIL t3_done got=%b exp=001", {clear, epoch});
        end
    endtask

    // Participant 1 requests twice
    task automatic test_duplicate();
        comb_mode = 1'b0;
        do_reset();
        cyc(); req_valid = 4'b0010; #1;
        total++;
        if (present !== 4'b0010) begin
            bad++; $display("FAIL t4_first got=%b exp=0010", present);
        end
        cyc(); #1;
        total++;
        if ({present, req_ready, dup_err} !== 9'b0000_1111_0) begin
            bad++; $display("FAIL t4_dup_req got=%b exp=000011110", {present, req_ready, dup_err});
        end
        cyc(); req_valid = 4'b0001; #1;
        total++;
        if ({present, dup_err} !== 5'b0001_1) begin
            bad++; $display("FAIL t4_dup_err got=%b exp=00011", {present, dup_err});
        end
        cyc(); req_valid = 4'b1100; #1;
        total++;
        if ({present, dup_err} !== 5'b1100_0) begin
            bad++; $display("FAIL t4_rest got=%b exp=11000", {present, dup_err});
        end
        cyc(); req_valid = '0; wake_ready = 4'b1111; #1;
        cyc(); #1;
        total++;
        if (wake_valid !== 4'b1111) begin
            bad++; $display("FAIL t4_wake got=%b exp=1111", wake_valid);
        end
        cyc(); #1;
        cyc(); wake_ready = '0; #1;
        total++;
        if (epoch !== 2'd1) begin
            bad++; $display("FAIL t4_epoch got=%0d exp=1", epoch);
        end
    endtask

    // Only participant 0 arrives for a long time
    task automatic test_timeout();
        int pulses;
        int first;
        pulses = 0;
        first  = -1;
        comb_mode = 1'b0;
        do_reset();
        cyc(); req_valid = 4'b0001; #1;
        if (timeout) begin pulses++; first = 1; end
        for (int c = 2; c <= 20; c++) begin
            cyc(); req_valid = '0; #1;
            if (timeout) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL t5_pulse_count got=%0d exp=1", pulses);
        end
        total++;
        if (first !== 12) begin
            bad++; $display("FAIL t5_pulse_cycle got=%0d exp=12", first);
        end
        cyc(); req_valid = 4'b1110; #1;
        total++;
        if (present !== 4'b1110) begin
            bad++; $display("FAIL t5_late got=%b exp=1110", present);
        end
        cyc(); req_valid = '0; wake_ready = 4'b1111; #1;
        cyc(); #1;
        total++;
        if (wake_valid !== 4'b1111) begin
            bad++; $display("FAIL t5_wake got=%b exp=1111", wake_valid);
        end
        cyc(); #1;
        cyc(); wake_ready = '0; #1;
        total++;
        if ({epoch, timeout} !== 3'b01_0) begin
            bad++; $display("FAIL t5_done got=%b exp=010", {epoch, timeout});
        end
    endtask

    // Epoch wrap with CNT_W=2, then reset during WAKE
    task automatic test_epoch_wrap_and_abort();
        logic [1:0] exp_ep [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        comb_mode = 1'b1;
        do_reset();
        for (int b = 0; b < 5; b++) begin
            cyc(); req_valid = 4'b1111; wake_ready = 4'b1111; #1;
            cyc(); req_valid = '0; #1;
            cyc(); #1;
            cyc(); #1;
            total++;
            if ({epoch, req_ready} !== {exp_ep[b], 4'b1111}) begin
                bad++; $display("FAIL t6_epoch b%0d got=%0d exp=%0d", b, epoch, exp_ep[b]);
            end
        end
        cyc(); req_valid = 4'b1111; wake_ready = '0; #1;
        cyc(); #1;
        total++;
        if (wake_valid !== 4'b1111) begin
            bad++; $display("FAIL t6_in_wake got=%b exp=1111", wake_valid);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({req_ready, present, clear, wake_valid, epoch, dup_err, timeout} !== 17'd0) begin
            bad++;
            $display("FAIL t6_abort got=%b exp=0",
                     {req_ready, present, clear, wake_valid, epoch, dup_err, timeout});
        end
        cyc();
        req_valid = '0;
        rstn = 1'b1;
        #1;
        total++;
        if ({req_ready, epoch, wake_valid} !== 10'b1111_00_0000) begin
            bad++; $display("FAIL t6_release got=%b exp=1111000000", {req_ready, epoch, wake_valid});
        end
    endtask

    // Single participant: each accept goes straight to WAKE
    task automatic test_single();
        do_reset();
        cyc(); rv1 = 1'b1; #1;
        total++;
        if ({pr1, wv1} !== 2'b10) begin
            bad++; $display("FAIL p1_present got=%b exp=10", {pr1, wv1});
        end
        cyc(); rv1 = 1'b0; wr1 = 1'b1; #1;
        total++;
        if ({wv1, rr1} !== 2'b10) begin
            bad++; $display("FAIL p1_wake got=%b exp=10", {wv1, rr1});
        end
        cyc(); #1;
        total++;
        if (cl1 !== 1'b1) begin
            bad++; $display("FAIL p1_clear got=%b exp=1", cl1);
        end
        cyc(); wr1 = 1'b0; #1;
        total++;
        if ({ep1, rr1, to1} !== {8'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL p1_done got=%0d/%b exp=1/1", ep1, rr1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        comb_mode = 1'b0;
        req_valid = '0; wake_ready = '0; rv1 = 1'b0; wr1 = 1'b0;
        test_reset();
        test_sequential();
        test_all_at_once();
        test_staggered_wake();
        test_duplicate();
        test_timeout();
        test_epoch_wrap_and_abort();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
